// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// The response tag records which port issued the read now coming back from memory.
package mem_arb_pkg;

    localparam int AW_DEF   = 30;
    localparam int DW_DEF   = 32;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        D    = 2'd2
    } rsp_tag_t;

endpackage

// File: rtl/arb_prio_starve.sv
// Two-input fixed-priority arbiter: the high port wins unless the low port has
// been passed over LIMIT times in a row while it was requesting.
module arb_prio_starve
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hi_req,
    input  logic lo_req,
    output logic hi_gnt,
    output logic lo_gnt
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] starve;
    logic                force_lo;

    // Grants are gated by reset so nothing is accepted while the block is held in reset.
    always_comb begin
        force_lo = (starve == LIM);
        hi_gnt   = rst & hi_req & ~(lo_req & force_lo);
        lo_gnt   = rst & lo_req & ~(hi_req & ~force_lo);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (lo_gnt || !lo_req) begin
            starve <= '0;
        end else if (hi_gnt && (starve != LIM)) begin
            starve <= starve + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, one-cycle-latency memory between the fetch and data ports,
// granting one access per cycle and routing each read word back to its issuer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wren,
    output logic          mem_rren,
    output logic          mem_en,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflict_cnt
);

    rsp_tag_t      rsp_tag;
    logic [AW-1:0] last_addr;

    arb_prio_starve #(
        .LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .hi_req (d_req),
        .lo_req (if_req),
        .hi_gnt (d_gnt),
        .lo_gnt (if_gnt)
    );

    // The address bus keeps its last value while idle to avoid needless toggling.
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_wren  = d_gnt & d_we;
        mem_rren  = if_gnt | (d_gnt & ~d_we);
        mem_wdata = d_wdata;
        if (d_gnt) begin
            mem_addr = d_addr;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end else begin
            mem_addr = last_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr <= '0;
        end else if (mem_en) begin
            last_addr <= mem_addr;
        end
    end

    // Writes and idle cycles leave NONE so only reads generate a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_tag <= NONE;
        end else if (if_gnt) begin
            rsp_tag <= IF;
        end else if (d_gnt && !d_we) begin
            rsp_tag <= D;
        end else begin
            rsp_tag <= NONE;
        end
    end

    assign if_rvalid = (rsp_tag == IF);
    assign d_rvalid  = (rsp_tag == D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (if_req && d_req && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, word-addressed main memory (30-bit word address, 32-bit data, registered read output, one-cycle read latency) between the CPU's instruction-fetch port and its load/store data port.
- Issues at most one memory access per cycle, pipelined, so a new access may be granted every cycle.
- Routes each returned read word to the port that issued it.
- Data port has priority, bounded by a starvation limit that guarantees fetch progress.

Parameters:
- AW, 30, word-address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, max consecutive data grants while fetch is requesting before fetch is forced through (range 1..15).

Ports:
- clk  in  1  system clock; memory is clocked on the same edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  DW  data read data.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wren  out  1  memory write enable.
- mem_rren  out  1  memory read enable.
- mem_en  out  1  memory access enable (E).
- mem_rdata  in  DW  memory registered read output.
- conflict_cnt  out  16  number of cycles in which both ports requested; saturating.

Behaviour:
- **Reset (rst = 0, async):**
  - State: starve counter = 0, rsp_tag = NONE, conflict_cnt = 0.
  - Outputs: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_wren and mem_rren are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0 or don't-care.
  - Reset mid-operation: an in-flight read is dropped; no rvalid follows deassertion.
- **Grant logic (combinational, same cycle as request):**
  - Only d_req: d_gnt = 1.
  - Only if_req: if_gnt = 1.
  - Both: d_gnt = 1, unless starve counter == STARVE_LIMIT, in which case if_gnt = 1.
  - Never both grants in one cycle. A request is accepted when req && gnt at a posedge.
  - Requesters hold req, addr and wdata stable until granted.
- **Starve counter (saturating at STARVE_LIMIT):**
  - +1 when d_gnt && if_req.
  - Cleared to 0 on any if_gnt or when if_req = 0.
- **Memory drive (combinational from the grant):**
  - mem_en = if_gnt | d_gnt.
  - mem_addr = address of the granted port.
  - mem_wren = d_gnt & d_we.
  - mem_rren = if_gnt | (d_gnt & ~d_we).
  - mem_wdata = d_wdata.
  - Idle: mem_en = 0; mem_addr holds its last value (the memory may read while E = 0, which is harmless).
- **Read return (latency exactly 1 cycle):**
  - rsp_tag is registered at grant: IF, D or NONE (writes and idle give NONE).
  - Next cycle: if_rvalid = (rsp_tag == IF) and d_rvalid = (rsp_tag == D).
  - rdata = mem_rdata, passed through for both ports.
  - Back-to-back grants each produce exactly one response, in order.
- **Writes:** complete at the grant edge and produce no response. A read of the same address granted in the following cycle returns the new data.
- **conflict_cnt:** +1 on every cycle with if_req && d_req; saturates at 0xFFFF.
- **Invariant:** no combinational path from mem_rdata to any grant.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef rsp_tag_t (NONE, IF, D);
  - constants AW_DEF = 30 and DW_DEF = 32;
  - constant STARVE_W = 4.
- One natural sub-module, arb_prio_starve: the two-input fixed-priority grant with the starvation counter. It is reusable for a later uncached/DMA port.
- Tag register, muxes and counter live in the top.

Test Plan:
- **Fetch only:** if_req = 1 with if_addr 0..3 on consecutive cycles, memory preloaded as word 0 = 0x20060005 and word 1 = 0x20070007 -> if_gnt = 1 each cycle; if_rvalid = 1 one cycle later with 0x20060005, 0x20070007, … in order.
- **Data write then read:** d_we = 1, addr 0x100, wdata 0xDEADBEEF; next cycle d_we = 0, addr 0x100 -> mem_wren pulse with no d_rvalid for the write; d_rvalid = 1 with 0xDEADBEEF two cycles after the write grant.
- **Contention with STARVE_LIMIT = 4:** if_req and d_req held high 10 cycles -> grant pattern D, D, D, D, IF, D, D, D, D, IF; conflict_cnt = 10; no cycle has both grants.
- **Reset mid-read:** grant a fetch at addr 5, assert rst = 0 before the next edge -> if_rvalid stays 0, all outputs at reset values, conflict_cnt = 0.
- **Idle and routing:** no requests for 5 cycles -> mem_en, mem_wren and mem_rren are 0 and both rvalids are 0. Then alternating IF-read / D-read -> each rdata appears only on the issuing port's rvalid.
